// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator.
// Drives f_pc toward the branch predictor and steers fetch with its prediction.
// Registers the F->D slot together with the prediction that was made for it.
// Tracks in-flight predicted branches in a FIFO and checks EXEC resolutions
// against the oldest entry. On a mismatch it raises a one-cycle flush and
// redirects fetch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall             downstream not ready; hold fetch and decode
//   f_predict_addr    predicted target for the current f_pc
//   f_predict_valid   predictor hit, predicted taken
//   d_is_branch       instruction at d_pc is a branch
//   x_resolve_valid   EXEC resolves the oldest in-flight branch
//   x_taken           actual branch outcome
//   x_target          actual branch target
//   f_pc              fetch PC (registered)
//   d_pc, d_valid     decode slot PC and live flag (registered)
//   flush             one-cycle squash of F/D after a misprediction (registered)
//   x_predict_res     resolved outcome back to the predictor (combinational)
//   pred_fifo_full    in-flight FIFO holds FIFO_DEPTH entries
//   err_sticky        FIFO overflow/underflow seen; cleared only by rst
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC   = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] f_predict_addr,
   input  logic        f_predict_valid,
   input  logic        d_is_branch,
   input  logic        x_resolve_valid,
   input  logic        x_taken,
   input  logic [31:0] x_target,
   output logic [31:0] f_pc,
   output logic [31:0] d_pc,
   output logic        d_valid,
   output logic        flush,
   output logic        x_predict_res,
   output logic        pred_fifo_full,
   output logic        err_sticky
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Prediction carried alongside the decode slot
   logic        d_pred_taken;
   logic [31:0] d_pred_addr;

   // In-flight branch FIFO storage and bookkeeping
   logic [31:0]      fifo_pc     [FIFO_DEPTH];
   logic             fifo_taken  [FIFO_DEPTH];
   logic [31:0]      fifo_target [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic        empty;
   logic        full;
   logic        advance;
   logic        mispredict;
   logic        push;
   logic        pop;
   logic        overflow;
   logic        underflow;
   logic [31:0] head_pc;
   logic        head_taken;
   logic [31:0] head_target;
   logic [31:0] redirect_pc;
   logic [31:0] next_f_pc;

   // Resolution check, FIFO handshakes and next fetch PC
   always_comb begin
      empty       = (count == CNT_W'(0));
      full        = (count == CNT_W'(FIFO_DEPTH));
      head_pc     = fifo_pc[rd_ptr];
      head_taken  = fifo_taken[rd_ptr];
      head_target = fifo_target[rd_ptr];
      advance     = !stall && !full;
      mispredict  = x_resolve_valid && !empty &&
                    ((x_taken != head_taken) || (x_taken && (x_target != head_target)));
      push        = d_valid && d_is_branch && advance && !mispredict;
      pop         = x_resolve_valid && !empty;
      // advance already excludes full; kept as a guard so a bad push is dropped and flagged
      overflow    = push && full;
      underflow   = x_resolve_valid && empty;
      redirect_pc = x_taken ? x_target : (head_pc + 32'd4);

      next_f_pc = f_pc;
      if (mispredict)           next_f_pc = redirect_pc;
      else if (!advance)        next_f_pc = f_pc;
      else if (f_predict_valid) next_f_pc = f_predict_addr;
      else                      next_f_pc = f_pc + 32'd4;
   end

   assign x_predict_res  = x_resolve_valid && x_taken;
   assign pred_fifo_full = full;

   // Fetch PC, F->D slot, flush and error state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_pc         <= RESET_PC;
         d_pc         <= 32'd0;
         d_valid      <= 1'b0;
         d_pred_taken <= 1'b0;
         d_pred_addr  <= 32'd0;
         flush        <= 1'b0;
         err_sticky   <= 1'b0;
      end else begin
         f_pc  <= next_f_pc;
         flush <= mispredict;
         if (mispredict) begin
            d_valid <= 1'b0;
         end else if (advance) begin
            d_pc         <= f_pc;
            d_valid      <= 1'b1;
            d_pred_taken <= f_predict_valid;
            d_pred_addr  <= f_predict_addr;
         end
         if (overflow || underflow) err_sticky <= 1'b1;
      end
   end

   // FIFO pointers and occupancy; a mispredict squashes every entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (mispredict) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)           rd_ptr <= rd_ptr + PTR_W'(1);
         if ((push && !full) && !pop)      count <= count + CNT_W'(1);
         else if (pop && !(push && !full)) count <= count - CNT_W'(1);
      end
   end

   // FIFO payload storage
   always_ff @(posedge clk) begin
      if (push && !full) begin
         fifo_pc[wr_ptr]     <= d_pc;
         fifo_taken[wr_ptr]  <= d_pred_taken;
         fifo_target[wr_ptr] <= d_pred_addr;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: sequential fetch, predictor steering,
// resolution outcomes, FIFO full backpressure, error flag and reset.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [31:0] f_predict_addr;
   logic        f_predict_valid;
   logic        d_is_branch;
   logic        x_resolve_valid;
   logic        x_taken;
   logic [31:0] x_target;
   logic [31:0] f_pc;
   logic [31:0] d_pc;
   logic        d_valid;
   logic        flush;
   logic        x_predict_res;
   logic        pred_fifo_full;
   logic        err_sticky;

   int n_vec = 0;
   int n_err = 0;

   fetch_pc_gen dut (
      .clk(clk), .rst(rst), .stall(stall),
      .f_predict_addr(f_predict_addr), .f_predict_valid(f_predict_valid),
      .d_is_branch(d_is_branch), .x_resolve_valid(x_resolve_valid),
      .x_taken(x_taken), .x_target(x_target),
      .f_pc(f_pc), .d_pc(d_pc), .d_valid(d_valid), .flush(flush),
      .x_predict_res(x_predict_res), .pred_fifo_full(pred_fifo_full),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      stall = 0; f_predict_addr = 0; f_predict_valid = 0; d_is_branch = 0;
      x_resolve_valid = 0; x_taken = 0; x_target = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1; clear_inputs();
      step();
      rst = 0;
   endtask

   // Leaves f_pc=0x1004, d_pc=0x1000 with FIFO holding {0x1014, taken, 0x1000}
   task automatic setup_taken_branch();
      do_reset();
      repeat (5) step();
      f_predict_valid = 1; f_predict_addr = 32'h1000;
      step();
      f_predict_valid = 0; f_predict_addr = 0; d_is_branch = 1;
      step();
      d_is_branch = 0;
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs();
      step();
      n_vec++; if (f_pc !== 32'h1000) begin n_err++; $display("FAIL reset_f_pc: got %h want %h", f_pc, 32'h1000); end
      n_vec++; if (d_pc !== 32'h0) begin n_err++; $display("FAIL reset_d_pc: got %h want 0", d_pc); end
      n_vec++; if ({d_valid, flush, pred_fifo_full, err_sticky, x_predict_res} !== 5'b0) begin
         n_err++; $display("FAIL reset_flags: got %b want 00000", {d_valid, flush, pred_fifo_full, err_sticky, x_predict_res}); end
      rst = 0;
   endtask

   task automatic test_sequential();
      do_reset();
      n_vec++; if (f_pc !== 32'h1000 || d_valid !== 1'b0) begin n_err++; $display("FAIL seq0: f_pc %h d_valid %b want 1000/0", f_pc, d_valid); end
      step();
      n_vec++; if (f_pc !== 32'h1004 || d_pc !== 32'h1000 || d_valid !== 1'b1) begin
         n_err++; $display("FAIL seq1: f_pc %h d_pc %h d_valid %b want 1004/1000/1", f_pc, d_pc, d_valid); end
      step();
      n_vec++; if (f_pc !== 32'h1008 || d_pc !== 32'h1004) begin n_err++; $display("FAIL seq2: f_pc %h d_pc %h want 1008/1004", f_pc, d_pc); end
      step();
      n_vec++; if (f_pc !== 32'h100C || d_pc !== 32'h1008) begin n_err++; $display("FAIL seq3: f_pc %h d_pc %h want 100c/1008", f_pc, d_pc); end
   endtask

   task automatic test_stall_hold();
      do_reset();
      step();
      stall = 1;
      step();
      n_vec++; if (f_pc !== 32'h1004 || d_pc !== 32'h1000 || d_valid !== 1'b1) begin
         n_err++; $display("FAIL stall_hold: f_pc %h d_pc %h d_valid %b want 1004/1000/1", f_pc, d_pc, d_valid); end
      stall = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      f_predict_valid = 1; f_predict_addr = 32'hFFFF_FFFC;
      step();
      n_vec++; if (f_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pred: got %h want fffffffc", f_pc); end
      f_predict_valid = 0; f_predict_addr = 0;
      step();
      n_vec++; if (f_pc !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want 0", f_pc); end
   endtask

   task automatic test_predict_taken();
      do_reset();
      repeat (5) step();
      n_vec++; if (f_pc !== 32'h1014) begin n_err++; $display("FAIL pt_start: got %h want 1014", f_pc); end
      f_predict_valid = 1; f_predict_addr = 32'h1000;
      step();
      n_vec++; if (f_pc !== 32'h1000 || d_pc !== 32'h1014) begin n_err++; $display("FAIL pt_redirect: f_pc %h d_pc %h want 1000/1014", f_pc, d_pc); end
      f_predict_valid = 0; f_predict_addr = 0; d_is_branch = 1;
      step();
      d_is_branch = 0;
      x_resolve_valid = 1; x_taken = 1; x_target = 32'h1000;
      #1;
      n_vec++; if (x_predict_res !== 1'b1) begin n_err++; $display("FAIL pt_res: got %b want 1", x_predict_res); end
      step();
      n_vec++; if (flush !== 1'b0 || f_pc !== 32'h1008 || d_pc !== 32'h1004) begin
         n_err++; $display("FAIL pt_correct: flush %b f_pc %h d_pc %h want 0/1008/1004", flush, f_pc, d_pc); end
      n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL pt_no_err: got %b want 0", err_sticky); end
      // A further resolve must find the FIFO empty
      x_taken = 0;
      step();
      x_resolve_valid = 0;
      n_vec++; if (err_sticky !== 1'b1 || flush !== 1'b0) begin
         n_err++; $display("FAIL pt_empty: err %b flush %b want 1/0", err_sticky, flush); end
   endtask

   task automatic test_mispredict_not_taken();
      do_reset();
      repeat (4) step();
      d_is_branch = 1;
      step();
      d_is_branch = 0;
      x_resolve_valid = 1; x_taken = 1; x_target = 32'h1014;
      #1;
      n_vec++; if (x_predict_res !== 1'b1) begin n_err++; $display("FAIL mnt_res: got %b want 1", x_predict_res); end
      step();
      x_resolve_valid = 0; x_taken = 0; x_target = 0;
      n_vec++; if (flush !== 1'b1 || f_pc !== 32'h1014 || d_valid !== 1'b0) begin
         n_err++; $display("FAIL mnt_flush: flush %b f_pc %h d_valid %b want 1/1014/0", flush, f_pc, d_valid); end
      step();
      n_vec++; if (flush !== 1'b0 || f_pc !== 32'h1018 || d_pc !== 32'h1014 || d_valid !== 1'b1) begin
         n_err++; $display("FAIL mnt_after: flush %b f_pc %h d_pc %h d_valid %b want 0/1018/1014/1", flush, f_pc, d_pc, d_valid); end
      x_resolve_valid = 1;
      step();
      x_resolve_valid = 0;
      n_vec++; if (err_sticky !== 1'b1 || flush !== 1'b0) begin
         n_err++; $display("FAIL mnt_empty: err %b flush %b want 1/0", err_sticky, flush); end
   endtask

   task automatic test_mispredict_taken_wrong();
      setup_taken_branch();
      x_resolve_valid = 1; x_taken = 0;
      #1;
      n_vec++; if (x_predict_res !== 1'b0) begin n_err++; $display("FAIL mtw_res: got %b want 0", x_predict_res); end
      step();
      x_resolve_valid = 0;
      n_vec++; if (flush !== 1'b1 || f_pc !== 32'h1018 || d_valid !== 1'b0) begin
         n_err++; $display("FAIL mtw_redirect: flush %b f_pc %h d_valid %b want 1/1018/0", flush, f_pc, d_valid); end
   endtask

   task automatic test_target_mismatch();
      setup_taken_branch();
      x_resolve_valid = 1; x_taken = 1; x_target = 32'h2000;
      step();
      x_resolve_valid = 0; x_taken = 0; x_target = 0;
      n_vec++; if (flush !== 1'b1 || f_pc !== 32'h2000) begin
         n_err++; $display("FAIL tgt_redirect: flush %b f_pc %h want 1/2000", flush, f_pc); end
   endtask

   task automatic test_full();
      do_reset();
      d_is_branch = 1;
      repeat (5) step();
      n_vec++; if (pred_fifo_full !== 1'b1 || f_pc !== 32'h1014 || d_pc !== 32'h1010) begin
         n_err++; $display("FAIL full_set: full %b f_pc %h d_pc %h want 1/1014/1010", pred_fifo_full, f_pc, d_pc); end
      step();
      n_vec++; if (f_pc !== 32'h1014 || d_pc !== 32'h1010) begin
         n_err++; $display("FAIL full_frozen: f_pc %h d_pc %h want 1014/1010", f_pc, d_pc); end
      x_resolve_valid = 1; x_taken = 0;
      step();
      x_resolve_valid = 0;
      n_vec++; if (pred_fifo_full !== 1'b0 || flush !== 1'b0 || f_pc !== 32'h1014) begin
         n_err++; $display("FAIL full_pop: full %b flush %b f_pc %h want 0/0/1014", pred_fifo_full, flush, f_pc); end
      step();
      n_vec++; if (f_pc !== 32'h1018 || d_pc !== 32'h1014 || pred_fifo_full !== 1'b1) begin
         n_err++; $display("FAIL full_resume: f_pc %h d_pc %h full %b want 1018/1014/1", f_pc, d_pc, pred_fifo_full); end
      // Stall and full together must not block a redirect
      d_is_branch = 0; stall = 1;
      x_resolve_valid = 1; x_taken = 1; x_target = 32'h3000;
      step();
      x_resolve_valid = 0; x_taken = 0; x_target = 0; stall = 0;
      n_vec++; if (flush !== 1'b1 || f_pc !== 32'h3000 || d_valid !== 1'b0 || pred_fifo_full !== 1'b0) begin
         n_err++; $display("FAIL stall_mispredict: flush %b f_pc %h d_valid %b full %b want 1/3000/0/0", flush, f_pc, d_valid, pred_fifo_full); end
      n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL full_no_err: got %b want 0", err_sticky); end
   endtask

   task automatic test_underflow();
      do_reset();
      step();
      x_resolve_valid = 1; x_taken = 0;
      step();
      x_resolve_valid = 0;
      n_vec++; if (err_sticky !== 1'b1 || flush !== 1'b0 || f_pc !== 32'h1008) begin
         n_err++; $display("FAIL underflow: err %b flush %b f_pc %h want 1/0/1008", err_sticky, flush, f_pc); end
      step();
      n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL err_sticky_hold: got %b want 1", err_sticky); end
   endtask

   // Continues from test_underflow state (err_sticky set)
   task automatic test_reset_mid_flush();
      d_is_branch = 1;
      step();
      d_is_branch = 0;
      x_resolve_valid = 1; x_taken = 1; x_target = 32'h4000;
      step();
      x_resolve_valid = 0; x_taken = 0; x_target = 0;
      n_vec++; if (flush !== 1'b1 || f_pc !== 32'h4000) begin
         n_err++; $display("FAIL rmf_pre: flush %b f_pc %h want 1/4000", flush, f_pc); end
      rst = 1;
      #1;
      n_vec++; if (f_pc !== 32'h1000 || d_pc !== 32'h0) begin
         n_err++; $display("FAIL rmf_pcs: f_pc %h d_pc %h want 1000/0", f_pc, d_pc); end
      n_vec++; if ({d_valid, flush, pred_fifo_full, err_sticky, x_predict_res} !== 5'b0) begin
         n_err++; $display("FAIL rmf_flags: got %b want 00000", {d_valid, flush, pred_fifo_full, err_sticky, x_predict_res}); end
      step();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_sequential();
      test_stall_hold();
      test_wrap();
      test_predict_taken();
      test_mispredict_not_taken();
      test_mispredict_taken_wrong();
      test_target_mismatch();
      test_full();
      test_underflow();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator that sits directly upstream of branch_predictor. It drives f_pc and consumes f_predict_addr/f_predict_valid to steer fetch, and registers the F->D prediction alongside d_pc. It keeps a FIFO of in-flight predicted branches and checks EXEC outcomes against them. It generates the flush/redirect on a misprediction and drives x_predict_res back to the predictor.

Parameters:
RESET_PC, 32'h0000_1000, f_pc value after reset
FIFO_DEPTH, 4, in-flight branch entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stall  in  1  downstream not ready; hold fetch
f_predict_addr  in  32  predicted target for current f_pc
f_predict_valid  in  1  predictor hit, predicted taken
d_is_branch  in  1  decode flags instruction at d_pc as branch
x_resolve_valid  in  1  EXEC resolves oldest in-flight branch this cycle
x_taken  in  1  actual branch outcome
x_target  in  32  actual branch target
f_pc  out  32  fetch PC (registered)
d_pc  out  32  PC of instruction in decode (registered)
d_valid  out  1  decode slot holds a live instruction
flush  out  1  one-cycle squash of F/D on misprediction
x_predict_res  out  1  outcome to predictor (=x_taken when resolving)
pred_fifo_full  out  1  FIFO holds FIFO_DEPTH entries
err_sticky  out  1  overflow/underflow seen; cleared only by rst

Behaviour:
- Reset (async, any cycle, including mid-redirect): f_pc=RESET_PC, d_pc=0, d_valid=0, flush=0, FIFO empty, err_sticky=0, x_predict_res=0.
- advance = !stall && !pred_fifo_full.
- Next f_pc priority, evaluated each clk edge:
  1) mispredict: x_taken ? x_target : head.pc+4. Overrides stall and full.
  2) !advance: hold.
  3) f_predict_valid: f_predict_addr.
  4) else f_pc+4, mod 2^32 (wrap from 0xFFFF_FFFC to 0).
- F->D register, on advance with no mispredict: d_pc<=f_pc, d_valid<=1, d_pred_taken<=f_predict_valid, d_pred_addr<=f_predict_addr.
  - On !advance: hold contents; d_valid unchanged.
  - On mispredict: d_valid<=0.
- FIFO entry = {pc, pred_taken, pred_target}.
  - Push {d_pc, d_pred_taken, d_pred_addr} when d_valid && d_is_branch && advance && no mispredict.
  - Push while full is impossible by construction (advance=0). If it is still attempted, drop it and set err_sticky.
  - Pop head when x_resolve_valid. Pop on empty: ignore and set err_sticky.
  - Simultaneous push and pop: both take effect; count unchanged.
- Mispredict (combinational on x_resolve_valid && FIFO non-empty) when:
  - x_taken != head.pred_taken, or
  - x_taken && x_target != head.pred_target.
- Mispredict effects next cycle:
  - flush=1 for exactly one cycle.
  - FIFO cleared (all younger entries squashed); a push in the same cycle is discarded.
  - f_pc redirected as above.
- x_predict_res = x_resolve_valid ? x_taken : 0, combinational, valid the same cycle as x_resolve_valid. The predictor pairs it with its own oldest entry.
- Correct prediction: pop only; no flush; fetch unaffected.
- Latency: predictor hit at f_pc -> f_pc equals target 1 cycle later. Resolve -> redirected f_pc and flush 1 cycle later.

Test Plan:
1. Reset, then 4 cycles with no hits, no stall -> f_pc 0x1000, 0x1004, 0x1008, 0x100C. d_pc lags f_pc by 1 cycle; d_valid=1 from cycle 2.
2. f_predict_valid=1, addr=0x1000 at f_pc=0x1014 -> next f_pc=0x1000. Then d_is_branch at d_pc=0x1014 pushes {0x1014,1,0x1000}. x_resolve_valid with x_taken=1, x_target=0x1000 -> no flush, FIFO empty.
3. Predicted not-taken branch at 0x100C pushed; resolve with x_taken=1, x_target=0x1014 -> flush=1 one cycle, f_pc=0x1014, d_valid=0, FIFO empty, x_predict_res=1 in the resolve cycle.
4. Predicted taken to 0x1000; resolve x_taken=0 -> f_pc=head.pc+4. Separately, taken resolve with target mismatch 0x2000 vs 0x1000 -> f_pc=0x2000.
5. Push 4 branches with no resolves -> pred_fifo_full=1, f_pc/d_pc frozen. One resolve (correct) -> full drops and fetch resumes. Stall=1 together with a mispredict -> redirect still taken.
6. x_resolve_valid on empty FIFO -> err_sticky=1, no flush. Assert rst mid-flush -> all outputs at reset values immediately.
